// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp: closed-loop DC-motor PWM driver for an H-bridge.
// Duty is proportional to |adc - dip_sw|, quantised to LEVELS steps, with the
// drive direction taken from the sign of the error. Level and direction change
// only at PWM period boundaries, and a reversal always passes through a period
// at level 0. Define MOTOR_PWM_RAMP_EN for a slew-limited soft start that moves
// one level per RAMP_PERIODS periods; without it the target is applied at once.
module motor_pwm_ramp #(
  parameter int unsigned ADC_W        = 8,
  parameter int unsigned PERIOD       = 5400000,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned RAMP_PERIODS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc,
  input  logic [ADC_W-1:0] dip_sw,
  output logic [2:0]       motor,
  output logic [1:0]       portc
);

  localparam int unsigned CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned LB    = $clog2(LEVELS);
  localparam int unsigned LW    = LB + 1;
  localparam int unsigned SHIFT = ADC_W - LB;
  localparam int unsigned STEP  = PERIOD / LEVELS;
  // One extra bit so that grade can reach PERIOD itself (100 % duty).
  localparam int unsigned GW    = CW + 1;

  if ((LEVELS < 2) || ((LEVELS & (LEVELS - 1)) != 0) || (LEVELS > (1 << ADC_W)) ||
      ((PERIOD % LEVELS) != 0) || (RAMP_PERIODS < 1)) begin : g_param_check
    $error("motor_pwm_ramp: invalid parameter set");
  end

  logic [ADC_W-1:0] adc_q, sw_q, mag;
  logic             tdir;
  logic [LW-1:0]    tgt, cur_q, cur_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q;
  logic             bound;
  logic [GW-1:0]    grade;

  // Register the raw inputs every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_q <= '0;
      sw_q  <= '0;
    end else begin
      adc_q <= adc;
      sw_q  <= dip_sw;
    end
  end

  // Error magnitude, requested direction and quantised target level.
  always_comb begin
    tdir = adc_q < sw_q;
    mag  = tdir ? (sw_q - adc_q) : (adc_q - sw_q);
    tgt  = '0;
    if (mag != '0) begin
      tgt = LW'((mag - ADC_W'(1)) >> SHIFT) + LW'(1);
    end
  end

  assign bound = (cnt_q == CW'(PERIOD - 1));
  assign grade = GW'(cur_q) * GW'(STEP);

  // Free-running period counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bound) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef MOTOR_PWM_RAMP_EN
  localparam int unsigned DW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          div_wrap;

  assign div_wrap = (div_q == DW'(RAMP_PERIODS - 1));

  // Ramp: one level per step boundary; a reversal first walks down to zero.
  always_comb begin
    cur_d = cur_q;
    dir_d = dir_q;
    div_d = div_q;
    if (bound) begin
      div_d = div_wrap ? '0 : div_q + DW'(1);
      if (div_wrap) begin
        if ((cur_q != '0) && (dir_q != tdir) && (tgt != '0)) begin
          cur_d = cur_q - LW'(1);
        end else if ((cur_q == '0) && (tgt != '0)) begin
          dir_d = tdir;
          cur_d = LW'(1);
        end else if (cur_q < tgt) begin
          cur_d = cur_q + LW'(1);
        end else if (cur_q > tgt) begin
          cur_d = cur_q - LW'(1);
        end
      end
    end
  end

  // Boundary-event divider that selects the step boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  // Direct: jump to the target, inserting one dead period on a reversal.
  always_comb begin
    cur_d = cur_q;
    dir_d = dir_q;
    if (bound) begin
      if ((dir_q != tdir) && (tgt != '0) && (cur_q != '0)) begin
        cur_d = '0;
      end else begin
        cur_d = tgt;
        // Direction may only change while the bridge is idle; zero error holds it.
        if ((cur_q == '0) && (tgt != '0)) begin
          dir_d = tdir;
        end
      end
    end
  end
`endif

  // Applied level and direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      dir_q <= dir_d;
    end
  end

  // Registered pin drivers; they trail cnt/cur by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      motor <= 3'b000;
      portc <= 2'b00;
    end else begin
      motor <= {cur_q != '0, {1'b0, cnt_q} < grade, dir_q};
      portc <= {(cur_q != tgt) || ((dir_q != tdir) && (tgt != '0)), cur_q != '0};
    end
  end

endmodule
